// File: rtl/parking_pkg.sv
// Shared types for the parking lot command driver: command codes, packed command, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package parking_pkg;

    localparam logic [1:0] CMD_IN   = 2'd0;
    localparam logic [1:0] CMD_OUT  = 2'd1;
    localparam logic [1:0] CMD_LEAK = 2'd2;
    localparam logic [1:0] CMD_RSVD = 2'd3;

    typedef struct packed {
        logic [1:0]  ctype;
        logic [15:0] plate;
        logic [2:0]  floor;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LEAK,
        ST_GAP
    } state_t;

    // True when every nibble of the plate is a decimal digit.
    function automatic logic plate_is_bcd(input logic [15:0] plate);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (plate[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/parking_cmd_fifo.sv
// Synchronous show-ahead command FIFO with registered occupancy count.
// Latency: a push at edge k is visible on head_dat after edge k.
// Backpressure: push ignored when full, pop ignored when empty.
module parking_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/parking_cmd_driver.sv
// Turns queued host commands into parking_lot_top pulses; PARKING_CMD_BCD_CHECK_EN drops non-BCD IN/OUT plates.
// Latency: push at edge k into an idle, empty driver shows on the lot outputs at edge k+2.
// Backpressure: cmd_ready = !full from registered occupancy; IN/OUT wait for !lot_busy, LEAK does not.
module parking_cmd_driver
    import parking_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GAP       = 1,
    parameter int LEAK_HOLD = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [15:0]              cmd_plate,
    input  logic [2:0]               cmd_floor,
    input  logic                     lot_busy,
    output logic [15:0]              license_plate,
    output logic                     in_mode,
    output logic                     out_mode,
    output logic                     leakage,
    output logic [2:0]               leakage_floor,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               issued_cnt,
    output logic                     err_drop
);

    localparam int LW = $clog2(LEAK_HOLD + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [LW-1:0] LEAK_LAST = LW'(LEAK_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    state_t          state;
    state_t          state_nxt;
    cmd_t            push_cmd;
    cmd_t            head;
    cmd_t            cmd_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            load;
    logic            drop;
    logic            dispatch;
    logic            plate_ok;
    logic            ready_q;
    logic [LW-1:0]   leak_cnt;
    logic [GW-1:0]   gap_cnt;

    assign push_cmd  = '{ctype: cmd_type, plate: cmd_plate, floor: cmd_floor};
    assign cmd_ready = ready_q & ~fifo_full;
    assign push      = cmd_valid & cmd_ready;

    parking_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (push_cmd),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef PARKING_CMD_BCD_CHECK_EN
    assign plate_ok = plate_is_bcd(head.plate);
`else
    assign plate_ok = 1'b1;
`endif

    // The last GAP cycle makes the same head decision as IDLE, so pulses can
    // start every 1+GAP cycles rather than paying an extra IDLE cycle.
    always_comb begin
        state_nxt = state;
        dispatch  = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_IDLE:  dispatch = 1'b1;
            ST_DRIVE: state_nxt = ST_GAP;
            ST_LEAK:  if (leak_cnt == LEAK_LAST) state_nxt = ST_GAP;
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    dispatch  = 1'b1;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase

        if (dispatch && !fifo_empty) begin
            if ((head.ctype == CMD_RSVD) ||
                (head.ctype == CMD_LEAK && head.floor == 3'd0) ||
                (head.ctype != CMD_LEAK && !plate_ok)) begin
                pop  = 1'b1;
                drop = 1'b1;
            end else if (head.ctype == CMD_LEAK) begin
                pop       = 1'b1;
                load      = 1'b1;
                state_nxt = ST_LEAK;
            end else if (!lot_busy) begin
                pop       = 1'b1;
                load      = 1'b1;
                state_nxt = ST_DRIVE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            leak_cnt <= '0;
            gap_cnt  <= '0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_q  <= 1'b1;
            if (load) cmd_q <= head;
            leak_cnt <= (state == ST_LEAK) ? leak_cnt + LW'(1) : '0;
            gap_cnt  <= (state == ST_GAP)  ? gap_cnt + GW'(1)  : '0;
        end
    end

    // Lot outputs are registered copies of the current state, one edge behind it.
    always_ff @(posedge clock) begin
        if (reset) begin
            license_plate <= '0;
            in_mode       <= 1'b0;
            out_mode      <= 1'b0;
            leakage       <= 1'b0;
            leakage_floor <= '0;
            issued_cnt    <= '0;
            err_drop      <= 1'b0;
        end else begin
            license_plate <= (state == ST_DRIVE) ? cmd_q.plate : '0;
            in_mode       <= (state == ST_DRIVE) && (cmd_q.ctype == CMD_IN);
            out_mode      <= (state == ST_DRIVE) && (cmd_q.ctype == CMD_OUT);
            leakage       <= (state == ST_LEAK);
            leakage_floor <= (state == ST_LEAK) ? cmd_q.floor : '0;
            err_drop      <= drop;
            if ((state == ST_DRIVE) || (state == ST_LEAK && leak_cnt == '0))
                issued_cnt <= issued_cnt + 8'd1;
        end
    end

endmodule
